io_bridge: RTL and testbench
============================

IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter: DEPTH, 4, entries per FIFO; power of two, at least 2.
REQ-002 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_ni  in  1  reset; asynchronous, active-low.
REQ-004 aob_i  in  8  CPU output byte.
REQ-005 out_we_i  in  1  CPU write strobe; one byte per asserted cycle.
REQ-006 in_re_i  in  1  CPU read strobe; pops one byte per asserted cycle.
REQ-007 aib_o  out  8  input-FIFO head byte to CPU; 8'h00 when empty.
REQ-008 in_rdy_o  out  1  input FIFO non-empty.
REQ-009 out_full_o  out  1  output FIFO full.
REQ-010 ext_in_data_i  in  8  external byte toward CPU.
REQ-011 ext_in_valid_i  in  1  external byte valid.
REQ-012 ext_in_ready_o  out  1  input FIFO not full.
REQ-013 ext_out_data_o  out  8  output-FIFO head byte.
REQ-014 ext_out_valid_o  out  1  output FIFO non-empty.
REQ-015 ext_out_ready_i  in  1  external sink accepts the head byte.
REQ-016 err_o  out  2  sticky errors: bit0 = output overflow, bit1 = input underflow.

Function
REQ-017 Two independent circular FIFOs, each DEPTH x 8: output path (CPU to external) and input path (external to CPU).
- Read and write pointers wrap modulo DEPTH.
- Occupancy counters are clog2(DEPTH)+1 bits wide.
REQ-018 Full, empty and all status outputs are decoded from the registered occupancy only; there is no combinational bypass from any input to a status output.
REQ-019 Output push: out_we_i=1 with output FIFO not full writes aob_i at the write pointer; ext_out_valid_o=1 on the next cycle when the FIFO was empty (1-cycle latency).
REQ-020 Output overflow: out_we_i=1 while full (pre-edge state) drops the byte and sets err_o[0]. The byte is dropped even if a pop occurs in the same cycle.
REQ-021 Output pop: transfer occurs when ext_out_valid_o and ext_out_ready_i are both 1 at the edge; the read pointer advances by one.
REQ-022 ext_out_data_o shows the head entry whenever ext_out_valid_o=1 and stays stable until a transfer occurs.
REQ-023 Input push: transfer occurs when ext_in_valid_i and ext_in_ready_o are both 1 at the edge; ext_in_data_i is stored; in_rdy_o=1 on the next cycle when the FIFO was empty.
REQ-024 Input pop: in_re_i=1 while in_rdy_o=1 advances the read pointer; aib_o shows the next entry, or 8'h00 when the FIFO becomes empty.
REQ-025 Input underflow: in_re_i=1 while empty makes no pointer change and sets err_o[1].
REQ-026 A simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged; both pointers advance.
REQ-027 A simultaneous push and pop on an empty FIFO performs the push only.
REQ-028 A pop and a push on a full input FIFO are not simultaneous, because ext_in_ready_o=0 when the FIFO is full.
REQ-029 err_o bits stay set until reset; there is no other clear path.
REQ-030 Count never exceeds DEPTH and never goes below 0.

Reset
REQ-031 While rst_ni=0, asynchronously:
- all pointers and counts go to 0;
- err_o=2'b00, aib_o=8'h00, in_rdy_o=0, ext_out_valid_o=0, out_full_o=0, ext_in_ready_o=1.
REQ-032 Reset asserted mid-operation discards all FIFO contents; no partial transfer completes in the reset cycle.
REQ-033 After release, the first edge with rst_ni=1 is a normal operating edge.
REQ-034 The FIFO storage arrays need no reset; their contents are never visible while the corresponding FIFO is empty.

Verification
REQ-035 Write 8'hA5 with out_we_i for 1 cycle, ext_out_ready_i=0 -> ext_out_valid_o=1 and ext_out_data_o=8'hA5 on the next cycle; assert ready -> valid=0 one cycle later.
REQ-036 Write 5 bytes 8'h01..8'h05 with DEPTH=4 and ready=0 -> out_full_o=1 after the 4th write; err_o=2'b01; draining yields 01,02,03,04 only.
REQ-037 Push 8'h3C then 8'hC3 on the external input -> in_rdy_o=1, aib_o=8'h3C; in_re_i for 1 cycle -> aib_o=8'hC3; a second read -> aib_o=8'h00, in_rdy_o=0.
REQ-038 in_re_i=1 with the input FIFO empty -> err_o[1]=1; pointers are unchanged, confirmed by a subsequent push/pop of 8'h77 returning 8'h77.
REQ-039 Hold the output FIFO at count 2, pulse out_we_i and ext_out_ready_i together for 6 cycles -> count stays 2, and data order is preserved across pointer wrap.
REQ-040 Assert rst_ni=0 between edges with both FIFOs holding data and err_o=2'b11 -> all outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_bridge.sv
// io_bridge: CPU <-> external byte bridge built from two independent
// DEPTH x 8 circular FIFOs.
//   Output path: the CPU writes bytes (aob_i/out_we_i), and the external
//                sink drains them with a valid/ready handshake
//                (ext_out_data_o/ext_out_valid_o/ext_out_ready_i).
//   Input path:  the external source pushes bytes with a valid/ready
//                handshake (ext_in_data_i/ext_in_valid_i/ext_in_ready_o),
//                and the CPU pops them (aib_o/in_rdy_o/in_re_i).
//   err_o: sticky error flags, cleared only by reset.
//          bit0 = output overflow, bit1 = input underflow.
// All status outputs are decoded from the registered occupancy counts.
module io_bridge #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] aob_i,
  input  logic       out_we_i,
  input  logic       in_re_i,
  output logic [7:0] aib_o,
  output logic       in_rdy_o,
  output logic       out_full_o,
  input  logic [7:0] ext_in_data_i,
  input  logic       ext_in_valid_i,
  output logic       ext_in_ready_o,
  output logic [7:0] ext_out_data_o,
  output logic       ext_out_valid_o,
  input  logic       ext_out_ready_i,
  output logic [1:0] err_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Output FIFO state
  logic [7:0]    o_mem [DEPTH];
  logic [AW-1:0] o_wr;
  logic [AW-1:0] o_rd;
  logic [CW-1:0] o_cnt;

  // Input FIFO state
  logic [7:0]    i_mem [DEPTH];
  logic [AW-1:0] i_wr;
  logic [AW-1:0] i_rd;
  logic [CW-1:0] i_cnt;

  logic [1:0]    err;

  // Status decode from registered counts
  logic o_full, o_empty, i_full, i_empty;
  assign o_full  = (o_cnt == FULL_CNT);
  assign o_empty = (o_cnt == '0);
  assign i_full  = (i_cnt == FULL_CNT);
  assign i_empty = (i_cnt == '0);

  // Transfer qualifiers; a write while full is dropped even if a pop
  // happens on the same edge, because fullness is judged pre-edge.
  logic o_push, o_pop, i_push, i_pop;
  assign o_push = out_we_i & ~o_full;
  assign o_pop  = ext_out_ready_i & ~o_empty;
  assign i_push = ext_in_valid_i & ~i_full;
  assign i_pop  = in_re_i & ~i_empty;

  // Storage arrays: no reset, contents hidden while empty
  always_ff @(posedge clk_i) begin
    if (o_push) o_mem[o_wr] <= aob_i;
    if (i_push) i_mem[i_wr] <= ext_in_data_i;
  end

  // Output FIFO pointers and count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      o_wr  <= '0;
      o_rd  <= '0;
      o_cnt <= '0;
    end else begin
      if (o_push) o_wr <= o_wr + AW'(1);
      if (o_pop)  o_rd <= o_rd + AW'(1);
      o_cnt <= o_cnt + CW'(o_push) - CW'(o_pop);
    end
  end

  // Input FIFO pointers and count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_wr  <= '0;
      i_rd  <= '0;
      i_cnt <= '0;
    end else begin
      if (i_push) i_wr <= i_wr + AW'(1);
      if (i_pop)  i_rd <= i_rd + AW'(1);
      i_cnt <= i_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  // Sticky error flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err <= 2'b00;
    end else begin
      err[0] <= err[0] | (out_we_i & o_full);
      err[1] <= err[1] | (in_re_i & i_empty);
    end
  end

  assign out_full_o      = o_full;
  assign ext_out_valid_o = ~o_empty;
  assign ext_out_data_o  = o_empty ? 8'h00 : o_mem[o_rd];
  assign ext_in_ready_o  = ~i_full;
  assign in_rdy_o        = ~i_empty;
  assign aib_o           = i_empty ? 8'h00 : i_mem[i_rd];
  assign err_o           = err;

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: self-checking bench for io_bridge with queue scoreboards
// for the output and input paths.
module tb_io_bridge;

  localparam int unsigned DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] aob_i = 8'h00;
  logic       out_we_i = 1'b0;
  logic       in_re_i = 1'b0;
  logic [7:0] aib_o;
  logic       in_rdy_o;
  logic       out_full_o;
  logic [7:0] ext_in_data_i = 8'h00;
  logic       ext_in_valid_i = 1'b0;
  logic       ext_in_ready_o;
  logic [7:0] ext_out_data_o;
  logic       ext_out_valid_o;
  logic       ext_out_ready_i = 1'b0;
  logic [1:0] err_o;

  io_bridge #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .aob_i(aob_i),
    .out_we_i(out_we_i),
    .in_re_i(in_re_i),
    .aib_o(aib_o),
    .in_rdy_o(in_rdy_o),
    .out_full_o(out_full_o),
    .ext_in_data_i(ext_in_data_i),
    .ext_in_valid_i(ext_in_valid_i),
    .ext_in_ready_o(ext_in_ready_o),
    .ext_out_data_o(ext_out_data_o),
    .ext_out_valid_o(ext_out_valid_o),
    .ext_out_ready_i(ext_out_ready_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  logic [7:0] out_q [$];
  logic [7:0] in_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One CPU write with the sink stalled; the model keeps it only if not full.
  task automatic write_out(input logic [7:0] b);
    out_we_i = 1'b1;
    aob_i    = b;
    if (out_q.size() < DEPTH) out_q.push_back(b);
    step();
    out_we_i = 1'b0;
  endtask

  task automatic push_in(input logic [7:0] b);
    ext_in_valid_i = 1'b1;
    ext_in_data_i  = b;
    if (in_q.size() < DEPTH) in_q.push_back(b);
    step();
    ext_in_valid_i = 1'b0;
  endtask

  task automatic drain_out();
    ext_out_ready_i = 1'b1;
    for (int i = 0; i < 2 * DEPTH && out_q.size() > 0; i++) begin
      check("drain_valid", 32'(ext_out_valid_o), 32'd1);
      check("drain_data", 32'(ext_out_data_o), 32'(out_q.pop_front()));
      step();
    end
    ext_out_ready_i = 1'b0;
    check("drain_empty", 32'(ext_out_valid_o), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_aib"}, 32'(aib_o), 32'h00);
    check({tag, "_in_rdy"}, 32'(in_rdy_o), 32'd0);
    check({tag, "_out_full"}, 32'(out_full_o), 32'd0);
    check({tag, "_out_valid"}, 32'(ext_out_valid_o), 32'd0);
    check({tag, "_in_ready"}, 32'(ext_in_ready_o), 32'd1);
    check({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    check_reset_values("rst");
    step();
    rst_ni = 1'b1;
    step();
    check_reset_values("post_rst");

    // Single byte through the output path
    write_out(8'hA5);
    check("a5_valid", 32'(ext_out_valid_o), 32'd1);
    check("a5_data", 32'(ext_out_data_o), 32'(out_q[0]));
    step();
    check("a5_stable", 32'(ext_out_data_o), 32'h A5);
    ext_out_ready_i = 1'b1;
    void'(out_q.pop_front());
    step();
    ext_out_ready_i = 1'b0;
    check("a5_gone", 32'(ext_out_valid_o), 32'd0);

    // Overflow: five writes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      write_out(8'(i));
      if (i == 4) check("ovf_full", 32'(out_full_o), 32'd1);
      if (i == 4) check("ovf_err_pre", 32'(err_o), 32'd0);
    end
    check("ovf_err", 32'(err_o), 32'b01);
    check("ovf_qsize", 32'(out_q.size()), 32'd4);
    drain_out();
    check("ovf_not_full", 32'(out_full_o), 32'd0);

    // Input path two-byte push and CPU reads
    push_in(8'h3C);
    push_in(8'hC3);
    check("in_rdy", 32'(in_rdy_o), 32'd1);
    check("in_head0", 32'(aib_o), 32'(in_q[0]));
    in_re_i = 1'b1;
    void'(in_q.pop_front());
    step();
    in_re_i = 1'b0;
    check("in_head1", 32'(aib_o), 32'(in_q[0]));
    in_re_i = 1'b1;
    void'(in_q.pop_front());
    step();
    in_re_i = 1'b0;
    check("in_empty_aib", 32'(aib_o), 32'h00);
    check("in_empty_rdy", 32'(in_rdy_o), 32'd0);
    check("err_sticky", 32'(err_o), 32'b01);

    // Underflow leaves pointers alone
    in_re_i = 1'b1;
    step();
    in_re_i = 1'b0;
    check("udf_err", 32'(err_o), 32'b11);
    check("udf_rdy", 32'(in_rdy_o), 32'd0);
    push_in(8'h77);
    check("udf_push_rdy", 32'(in_rdy_o), 32'd1);
    check("udf_push_data", 32'(aib_o), 32'(in_q[0]));
    in_re_i = 1'b1;
    void'(in_q.pop_front());
    step();
    in_re_i = 1'b0;
    check("udf_pop_rdy", 32'(in_rdy_o), 32'd0);

    // Steady count of 2 with simultaneous push and pop across pointer wrap
    write_out(8'h10);
    write_out(8'h11);
    for (int i = 0; i < 6; i++) begin
      out_we_i        = 1'b1;
      aob_i           = 8'(8'h20 + i);
      ext_out_ready_i = 1'b1;
      check("wrap_data", 32'(ext_out_data_o), 32'(out_q.pop_front()));
      out_q.push_back(8'(8'h20 + i));
      step();
    end
    out_we_i        = 1'b0;
    ext_out_ready_i = 1'b0;
    check("wrap_valid", 32'(ext_out_valid_o), 32'd1);
    check("wrap_not_full", 32'(out_full_o), 32'd0);
    check("wrap_qsize", 32'(out_q.size()), 32'd2);
    drain_out();

    // Asynchronous reset mid-operation
    write_out(8'h81);
    write_out(8'h82);
    push_in(8'h44);
    check("pre_rst_err", 32'(err_o), 32'b11);
    check("pre_rst_valid", 32'(ext_out_valid_o), 32'd1);
    check("pre_rst_rdy", 32'(in_rdy_o), 32'd1);
    #3;
    rst_ni = 1'b0;
    #1;
    check_reset_values("async_rst");
    out_q.delete();
    in_q.delete();
    #2;
    rst_ni = 1'b1;
    step();
    check_reset_values("after_rst");

    // Push and pop together on an empty input FIFO: push only, underflow flagged
    ext_in_valid_i = 1'b1;
    ext_in_data_i  = 8'h66;
    in_re_i        = 1'b1;
    in_q.push_back(8'h66);
    step();
    ext_in_valid_i = 1'b0;
    in_re_i        = 1'b0;
    check("empty_both_rdy", 32'(in_rdy_o), 32'd1);
    check("empty_both_data", 32'(aib_o), 32'(in_q[0]));
    check("empty_both_err", 32'(err_o), 32'b10);

    // Normal output transfer after reset
    write_out(8'h5A);
    drain_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
